riscv_alu_wb_buffer: RTL

//  Writeback buffer directly downstream of the basic ALU in the shared-DSP EX stage.

---
 rtl/riscv_alu_wb_buffer.sv | 99 +++++++++
 1 files changed

// File: rtl/riscv_alu_wb_buffer.sv
// ============================================================================
// riscv_alu_wb_buffer : in-order ALU result FIFO feeding the regfile write port
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_alu_wb_buffer #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid_i,
  input  logic [31:0]                  alu_result_i,
  input  logic                         regfile_we_i,
  input  logic [ADDR_WIDTH-1:0]        regfile_waddr_i,
  output logic                         ex_ready_o,
  output logic                         regfile_we_o,
  output logic [ADDR_WIDTH-1:0]        regfile_waddr_o,
  output logic [31:0]                  regfile_wdata_o,
  input  logic                         wb_ready_i,
  input  logic [ADDR_WIDTH-1:0]        fwd_raddr_i,
  output logic                         fwd_hit_o,
  output logic [31:0]                  fwd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   WRAP_SUM = (PTR_W + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [31:0]           data_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic                  accept;
  logic                  enq;
  logic                  deq;
  logic [PTR_W:0]        scan_sum;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign ex_ready_o   = (count < FULL_CNT);
  assign regfile_we_o = (count != '0);
  assign occupancy_o  = count;

  // Instructions with no write or targeting x0 are consumed but never stored.
  assign accept = alu_valid_i & ex_ready_o;
  assign enq    = accept & regfile_we_i & (regfile_waddr_i != '0);
  assign deq    = regfile_we_o & wb_ready_i;

  assign regfile_waddr_o = regfile_we_o ? addr_mem[rd_ptr] : '0;
  assign regfile_wdata_o = regfile_we_o ? data_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      if (enq && !deq)      count <= count + 1'b1;
      else if (deq && !enq) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_mem[wr_ptr] <= regfile_waddr_i;
      data_mem[wr_ptr] <= alu_result_i;
    end
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    scan_sum   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_sum = {1'b0, rd_ptr} + (PTR_W + 1)'(i);
      if (scan_sum >= WRAP_SUM) scan_sum = scan_sum - WRAP_SUM;
      if ((CNT_W'(i) < count) && (fwd_raddr_i != '0) &&
          (addr_mem[scan_sum[PTR_W-1:0]] == fwd_raddr_i)) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_mem[scan_sum[PTR_W-1:0]];
      end
    end
  end

endmodule

`default_nettype wire
